// File: rtl/branch_ctrl.sv
// Decode-side branch resolver for LEGv8: classifies branches, waits on pending flag writers,
// issues a one-cycle redirect to fetch and squashes wrong-path instructions afterwards.
module branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned LINK_REG     = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [63:0] instr_pc,
    input  logic [63:0] rt_val,
    input  logic [63:0] rn_val,
    input  logic        flag_n,
    input  logic        flag_z,
    input  logic        flag_c,
    input  logic        flag_v,
    input  logic        flag_pending,
    output logic        is_BR,
    output logic        UncondBr,
    output logic        BrTaken,
    output logic [25:0] Imm26,
    output logic [18:0] Imm19,
    output logic [63:0] BR_addr,
    output logic [63:0] cur_pc,
    output logic        flush,
    output logic        lr_we,
    output logic [63:0] lr_data
);

    localparam int unsigned FlushLen  = (FLUSH_CYCLES == 0) ? 1 : FLUSH_CYCLES;
    localparam logic [2:0]  FlushLoad = 3'(FlushLen - 1);
    // X31 is the zero register, so a link into it is dropped.
    localparam logic        LinkWritable = (LINK_REG != 31);

    typedef enum logic [1:0] {StIdle, StWaitFlags, StRedirect, StFlush} state_e;
    typedef enum logic [2:0] {KindNone, KindB, KindBl, KindCbz, KindBcond, KindBr} kind_e;

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d, dec_kind;
    logic [25:0] imm_q, imm_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] rn_q, rn_d;
    logic        taken_q, taken_d;
    logic [2:0]  cnt_q, cnt_d;

    function automatic logic cond_met(input logic [3:0] cond, input logic n, input logic z,
                                      input logic c, input logic v);
        logic r;
        unique case (cond)
            4'h0: r = z;
            4'h1: r = !z;
            4'h2: r = c;
            4'h3: r = !c;
            4'h4: r = n;
            4'h5: r = !n;
            4'h6: r = v;
            4'h7: r = !v;
            4'h8: r = c && !z;
            4'h9: r = !(c && !z);
            4'hA: r = (n == v);
            4'hB: r = (n != v);
            4'hC: r = !z && (n == v);
            4'hD: r = !(!z && (n == v));
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    always_comb begin
        dec_kind = KindNone;
        if (instr[31:26] == 6'b000101)             dec_kind = KindB;
        else if (instr[31:26] == 6'b100101)        dec_kind = KindBl;
        else if (instr[31:24] == 8'b10110100)      dec_kind = KindCbz;
        else if (instr[31:24] == 8'b01010100)      dec_kind = KindBcond;
        else if (instr[31:21] == 11'b11010110000)  dec_kind = KindBr;
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        rn_d        = rn_q;
        taken_d     = taken_q;
        cnt_d       = cnt_q;
        instr_ready = 1'b0;
        is_BR       = 1'b0;
        UncondBr    = 1'b0;
        BrTaken     = 1'b0;
        flush       = 1'b0;
        lr_we       = 1'b0;
        lr_data     = '0;

        unique case (state_q)
            StIdle: begin
                instr_ready = reset;
                if (instr_valid && dec_kind != KindNone) begin
                    kind_d = dec_kind;
                    imm_d  = instr[25:0];
                    pc_d   = instr_pc;
                    if (dec_kind == KindBr) rn_d = rn_val;
                    if (dec_kind == KindCbz) begin
                        taken_d = (rt_val == '0);
                    end else if (dec_kind == KindBcond) begin
                        taken_d = cond_met(instr[3:0], flag_n, flag_z, flag_c, flag_v);
                    end else begin
                        taken_d = 1'b1;
                    end
                    state_d = (dec_kind == KindBcond && flag_pending) ? StWaitFlags : StRedirect;
                end
            end
            StWaitFlags: begin
                if (!flag_pending) begin
                    taken_d = cond_met(imm_q[3:0], flag_n, flag_z, flag_c, flag_v);
                    state_d = StRedirect;
                end
            end
            StRedirect: begin
                unique case (kind_q)
                    KindB: begin
                        UncondBr = 1'b1;
                        BrTaken  = 1'b1;
                    end
                    KindBl: begin
                        UncondBr = 1'b1;
                        BrTaken  = 1'b1;
                        lr_we    = LinkWritable;
                        lr_data  = pc_q + 64'd4;
                    end
                    KindBr:              is_BR   = 1'b1;
                    KindCbz, KindBcond:  BrTaken = taken_q;
                    default: ;
                endcase
                if (BrTaken || is_BR) begin
                    state_d = StFlush;
                    cnt_d   = FlushLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                flush = 1'b1;
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            kind_q  <= KindNone;
            imm_q   <= '0;
            pc_q    <= '0;
            rn_q    <= '0;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            rn_q    <= rn_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
        end
    end

    // Target fields hold the last accepted branch; fetch only looks at them during a redirect.
    assign Imm26   = imm_q;
    assign Imm19   = imm_q[23:5];
    assign cur_pc  = pc_q;
    assign BR_addr = rn_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomised scoreboard bench for branch_ctrl: the driver builds per-cycle expectations from
// transaction-level branch rules, and a negedge monitor pops and compares them.
module tb_branch_ctrl;

    localparam int unsigned FC = 3;
    localparam int unsigned LR = 30;

    logic        clk, reset, instr_valid, instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc, rt_val, rn_val;
    logic        flag_n, flag_z, flag_c, flag_v, flag_pending;
    logic        is_BR, UncondBr, BrTaken, flush, lr_we;
    logic [25:0] Imm26;
    logic [18:0] Imm19;
    logic [63:0] BR_addr, cur_pc, lr_data;

    branch_ctrl #(.FLUSH_CYCLES(FC), .LINK_REG(LR)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .rt_val(rt_val), .rn_val(rn_val),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .flag_pending(flag_pending), .is_BR(is_BR), .UncondBr(UncondBr), .BrTaken(BrTaken),
        .Imm26(Imm26), .Imm19(Imm19), .BR_addr(BR_addr), .cur_pc(cur_pc), .flush(flush),
        .lr_we(lr_we), .lr_data(lr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        ready, is_br, uncond, taken, flush, lr_we, chk_f, chk_br, chk_lr;
        logic [25:0] imm26;
        logic [18:0] imm19;
        logic [63:0] pc, br_addr, lr_data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam int KNone = 0, KB = 1, KBl = 2, KCbz = 3, KBcond = 4, KBr = 5;

    function automatic int model_kind(input logic [31:0] ins);
        if (ins[31:26] == 6'b000101) return KB;
        if (ins[31:26] == 6'b100101) return KBl;
        if (ins[31:24] == 8'b10110100) return KCbz;
        if (ins[31:24] == 8'b01010100) return KBcond;
        if (ins[31:21] == 11'b11010110000) return KBr;
        return KNone;
    endfunction

    // Conditions come in complementary pairs: odd codes invert the even base, 14/15 always.
    function automatic bit cond_holds(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, base;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: return 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

    function automatic exp_t quiet(input logic rdy);
        exp_t e;
        e = '0;
        e.ready = rdy;
        return e;
    endfunction

    function automatic exp_t model_redirect(input logic [31:0] ins, input logic [63:0] pc,
                                            input logic [63:0] rt, input logic [63:0] rn,
                                            input logic [3:0] f);
        exp_t e;
        e = '0;
        e.chk_f = 1'b1;
        e.imm26 = ins[25:0];
        e.imm19 = ins[23:5];
        e.pc    = pc;
        case (model_kind(ins))
            KB: begin e.uncond = 1'b1; e.taken = 1'b1; end
            KBl: begin
                e.uncond  = 1'b1;
                e.taken   = 1'b1;
                e.lr_we   = (LR != 31);
                e.chk_lr  = 1'b1;
                e.lr_data = pc + 64'd4;
            end
            KCbz:   e.taken = (rt == 64'd0);
            KBcond: e.taken = cond_holds(ins[3:0], f);
            KBr: begin e.is_br = 1'b1; e.chk_br = 1'b1; e.br_addr = rn; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk1(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    always begin : monitor
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk1("instr_ready", 64'(instr_ready), 64'(e.ready));
            chk1("is_BR", 64'(is_BR), 64'(e.is_br));
            chk1("UncondBr", 64'(UncondBr), 64'(e.uncond));
            chk1("BrTaken", 64'(BrTaken), 64'(e.taken));
            chk1("flush", 64'(flush), 64'(e.flush));
            chk1("lr_we", 64'(lr_we), 64'(e.lr_we));
            if (e.chk_f) begin
                chk1("Imm26", 64'(Imm26), 64'(e.imm26));
                chk1("Imm19", 64'(Imm19), 64'(e.imm19));
                chk1("cur_pc", cur_pc, e.pc);
            end
            if (e.chk_br) chk1("BR_addr", BR_addr, e.br_addr);
            if (e.chk_lr) chk1("lr_data", lr_data, e.lr_data);
        end
    end

    task automatic cyc(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        {flag_n, flag_z, flag_c, flag_v} = f;
    endtask

    task automatic scramble();
        instr_valid  = 1'($urandom);
        instr        = $urandom;
        instr_pc     = {$urandom, $urandom};
        rt_val       = {$urandom, $urandom};
        rn_val       = {$urandom, $urandom};
        flag_pending = 1'($urandom);
        set_flags(4'($urandom));
    endtask

    task automatic idle_cycle();
        scramble();
        instr_valid = 1'b0;
        cyc(quiet(1'b1));
    endtask

    // One complete transaction: accept, optional flag waits, redirect, flush.
    task automatic run_txn(input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] rt,
                           input logic [63:0] rn, input logic [3:0] f, input int waits_in);
        int   kind;
        int   waits;
        exp_t e;
        kind  = model_kind(ins);
        waits = (kind == KBcond) ? waits_in : 0;
        scramble();
        instr_valid = 1'b1;
        instr       = ins;
        instr_pc    = pc;
        rt_val      = rt;
        rn_val      = rn;
        if (kind == KBcond) begin
            flag_pending = (waits > 0);
            if (waits == 0) set_flags(f);
        end
        cyc(quiet(1'b1));
        if (kind == KNone) return;
        for (int w = 1; w <= waits; w++) begin
            scramble();
            flag_pending = (w < waits);
            if (w == waits) set_flags(f);
            cyc(quiet(1'b0));
        end
        e = model_redirect(ins, pc, rt, rn, f);
        scramble();
        cyc(e);
        if (e.taken || e.is_br) begin
            for (int i = 0; i < FC; i++) begin
                scramble();
                e = quiet(1'b0);
                e.flush = 1'b1;
                cyc(e);
            end
        end
    endtask

    function automatic logic [31:0] rand_instr(input int kind);
        logic [31:0] ins;
        case (kind)
            KB:     ins = {6'b000101, 26'($urandom)};
            KBl:    ins = {6'b100101, 26'($urandom)};
            KCbz:   ins = {8'b10110100, 24'($urandom)};
            KBcond: ins = {8'b01010100, 24'($urandom)};
            KBr:    ins = {11'b11010110000, 21'($urandom)};
            default: begin
                ins = $urandom;
                while (model_kind(ins) != KNone) ins = $urandom;
            end
        endcase
        return ins;
    endfunction

    initial begin : watchdog
        #1_000_000;
        errors++;
        $display("FAIL watchdog: bench did not complete within time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : driver
        exp_t        e;
        logic [31:0] ins;
        logic [63:0] rt;
        int          kind;

        reset = 1'b0;
        scramble();
        @(posedge clk);
        #1;
        // Still in reset: every output must be zero, ready included.
        scramble();
        instr_valid = 1'b1;
        e = quiet(1'b0);
        e.chk_f  = 1'b1;
        e.chk_br = 1'b1;
        e.chk_lr = 1'b1;
        cyc(e);
        reset = 1'b1;
        idle_cycle();

        run_txn({6'b000101, 26'd8}, 64'h100, 64'd1, 64'd2, 4'h0, 0);
        run_txn({6'b100101, 26'h3}, 64'h200, 64'd1, 64'd2, 4'h0, 0);
        run_txn({8'b10110100, 19'h12, 5'd3}, 64'h300, 64'd0, 64'd9, 4'h0, 0);
        run_txn({8'b10110100, 19'h13, 5'd4}, 64'h308, 64'd5, 64'd9, 4'h0, 0);
        idle_cycle();
        run_txn({8'b01010100, 19'h20, 5'h0}, 64'h400, 64'd1, 64'd1, 4'b0100, 3);
        run_txn({11'b11010110000, 11'h7C0, 5'd7, 5'd0}, 64'h500, 64'd1, 64'h4000, 4'h0, 0);
        run_txn({8'b01010100, 19'h21, 5'hC}, 64'h600, 64'd1, 64'd1, 4'b1000, 0);
        run_txn({8'b01010100, 19'h22, 5'hC}, 64'h604, 64'd1, 64'd1, 4'b1001, 1);

        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 5);
            ins  = rand_instr(kind);
            rt   = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom, $urandom};
            run_txn(ins, {$urandom, $urandom}, rt, {$urandom, $urandom}, 4'($urandom),
                    $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        // Reset in the middle of a flush: flush drops and the block comes back idle.
        scramble();
        instr_valid = 1'b1;
        instr       = {6'b000101, 26'h55};
        instr_pc    = 64'h700;
        cyc(quiet(1'b1));
        scramble();
        cyc(model_redirect({6'b000101, 26'h55}, 64'h700, 64'd0, 64'd0, 4'h0));
        scramble();
        e = quiet(1'b0);
        e.flush = 1'b1;
        cyc(e);
        scramble();
        reset = 1'b0;
        cyc(e);
        reset = 1'b1;
        scramble();
        instr_valid = 1'b0;
        e = quiet(1'b1);
        e.chk_f = 1'b1;
        cyc(e);
        idle_cycle();

        // Reset while waiting on flags: the pending B.cond must never redirect.
        scramble();
        instr_valid  = 1'b1;
        instr        = {8'b01010100, 19'h33, 5'hE};
        instr_pc     = 64'h800;
        flag_pending = 1'b1;
        cyc(quiet(1'b1));
        scramble();
        flag_pending = 1'b1;
        reset        = 1'b0;
        cyc(quiet(1'b0));
        reset        = 1'b1;
        scramble();
        instr_valid  = 1'b0;
        flag_pending = 1'b0;
        e = quiet(1'b1);
        e.chk_f = 1'b1;
        cyc(e);
        idle_cycle();
        idle_cycle();

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
